vec_tx_port: RTL
================

// Module: vec_tx_port
//
// PURPOSE
// Transmit side of the tile-to-tile vector write link. Accepts result vectors
// from the vector FU and drives them into a neighbour tile's regfile write port
// (wen + NUM_INPUTS x WIDTH data), then waits for that port's one-cycle-late
// wr_ack. Retries on a missing ack and flags an error after MAX_RETRY retries.
// Sits at each tile's outbound network edge, one instance per neighbour link.
//
// PARAMETERS
// WIDTH       16  element width, bits
// NUM_INPUTS  4   elements per vector (matches neighbour regfile set size)
// DEPTH       2   outbound FIFO depth in vectors; power of two, >= 2
// MAX_RETRY   3   retransmissions allowed after the first send before err
// CNT_W       16  width of tx_count
//
// PORTS
// clk        in   1                    clock, all state on posedge
// reset      in   1                    synchronous, active-high
// in_valid   in   1                    FU offers a vector
// in_ready   out  1                    FIFO can accept; push = in_valid & in_ready
// in_data    in   WIDTH x NUM_INPUTS   vector from FU, element 0 = lowest reg
// wen        out  1                    write enable to neighbour regfile port
// w_data     out  WIDTH x NUM_INPUTS   write data to neighbour regfile port
// wr_ack     in   1                    neighbour ack, valid the cycle after a write
// err_clr    in   1                    drop stalled head vector, leave ERR
// busy       out  1                    FIFO non-empty or FSM not IDLE
// err        out  1                    sticky retry-exhausted flag
// tx_count   out  CNT_W                acknowledged vectors, wraps mod 2^CNT_W
//
// BEHAVIOUR
// - Reset: FIFO flushed, FSM=IDLE, retry_cnt=0, wen=0, w_data=0, err=0,
//   tx_count=0, busy=0. in_ready=0 while reset is high, !full otherwise.
// - FIFO: circular, wrapping rd/wr pointers plus an occupancy count.
//   in_ready = !full; there is no bypass when full. A push and a pop in the
//   same cycle leave the count unchanged. Entries leave in arrival order.
// - w_data = FIFO head when wen=1, else all zeros.
// - FSM states:
//   IDLE : if FIFO is non-empty, go to SEND.
//   SEND : wen=1 for exactly one cycle; go to WAIT.
//   WAIT : wen=0; sample wr_ack.
//     wr_ack=1 : pop head; tx_count++; retry_cnt=0.
//                Go to SEND if another entry remains (count>1 or a push this
//                cycle), else go to IDLE.
//     wr_ack=0 and retry_cnt<MAX_RETRY : retry_cnt++; go to SEND with the
//                same head.
//     wr_ack=0 and retry_cnt==MAX_RETRY : err<=1; go to ERR.
//   ERR  : wen=0; head is held; pushes are still accepted while not full.
//          err_clr=1 pops the head, sets retry_cnt=0 and err=0, and goes to
//          IDLE. err_clr is ignored in every other state.
// - Throughput: at most one vector per 2 cycles. A dropped write (neighbour
//   busy reading) costs 2 cycles per retry.
// - wr_ack is ignored outside WAIT. Spurious acks are discarded and have no
//   effect on tx_count.
// - The neighbour's ack is shared across its write ports. The integration
//   schedule ensures no other port on that regfile writes in the cycle this
//   port sends.
// - Reset mid-operation: any in-flight vector is dropped and FIFO contents
//   are lost. A late wr_ack in the cycle after reset deasserts is ignored
//   (FSM is in IDLE).
//
// STRUCTURE
// - cgra_pkg: tx_state_e {IDLE, SEND, WAIT, ERR}; shared constants
//   VEC_WIDTH=16 and VEC_LANES=4, used as parameter defaults here and in
//   the regfile.
// - Sub-module vec_fifo (WIDTH*NUM_INPUTS wide, DEPTH deep, push/pop/full/
//   empty/count). The FSM, retry counter and tx_count live in vec_tx_port.
//
// TESTING
// 1 Push {1,2,3,4}; ack one cycle after wen -> exactly one wen pulse with
//   w_data={1,2,3,4}; tx_count=1; busy=0 two cycles later.
// 2 Push 3 vectors back-to-back with immediate acks -> wen every 2nd cycle in
//   order; in_ready low while 2 entries are queued; tx_count=3.
// 3 Withhold the ack for the first send of {5,6,7,8} only -> second wen
//   carries identical data; tx_count increments once.
// 4 Never ack, MAX_RETRY=3 -> 4 wen pulses, then err=1 and wen stays 0.
//   Next, err_clr=1 -> head dropped and the queued vector is sent.
// 5 Assert reset in WAIT and ack after reset deasserts -> wen=0, FIFO empty,
//   tx_count=0, busy=0.
// 6 Pulse wr_ack in IDLE with the FIFO empty -> tx_count unchanged, no wen,
//   FSM stays IDLE.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared CGRA types and constants for the tile-to-tile vector link.
// Lane width and count are the parameter defaults used by the tx port and the regfile.
package cgra_pkg;

  localparam int VEC_WIDTH = 16;
  localparam int VEC_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/vec_fifo.sv
// Circular outbound vector FIFO with wrapping pointers and an occupancy count.
// The head entry is read combinationally so the sender can drive it in the same cycle.
module vec_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; validity is tracked entirely by the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/vec_tx_port.sv
// Outbound vector write link: queues FU results, writes them into a neighbour
// regfile port, and retransmits until acked or the retry budget runs out.
module vec_tx_port
  import cgra_pkg::*;
#(
  parameter int WIDTH      = VEC_WIDTH,
  parameter int NUM_INPUTS = VEC_LANES,
  parameter int DEPTH      = 2,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_INPUTS-1:0][WIDTH-1:0]      in_data,
  output logic                                  wen,
  output logic [NUM_INPUTS-1:0][WIDTH-1:0]      w_data,
  input  logic                                  wr_ack,
  input  logic                                  err_clr,
  output logic                                  busy,
  output logic                                  err,
  output logic [CNT_W-1:0]                      tx_count
);

  localparam int DATA_W = WIDTH * NUM_INPUTS;
  localparam int FCW    = $clog2(DEPTH + 1);
  localparam int RW     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX_C = RW'(MAX_RETRY);

  tx_state_e  state_reg, state_next;
  logic [RW-1:0]    retry_reg, retry_next;
  logic [CNT_W-1:0] tx_count_reg, tx_count_next;
  logic             err_reg, err_next;

  logic                              push;
  logic                              pop;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [FCW-1:0]                    fifo_count;
  logic [DATA_W-1:0]                 fifo_head;
  logic [NUM_INPUTS-1:0][WIDTH-1:0]  head;

  assign in_ready = !reset && !fifo_full;
  assign push     = in_valid && in_ready;
  assign head     = fifo_head;

  vec_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      retry_reg    <= '0;
      tx_count_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      retry_reg    <= retry_next;
      tx_count_reg <= tx_count_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    retry_next    = retry_reg;
    tx_count_next = tx_count_reg;
    err_next      = err_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = SEND;
        end
      end
      SEND: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (wr_ack) begin
          pop           = 1'b1;
          tx_count_next = tx_count_reg + CNT_W'(1);
          retry_next    = '0;
          // A push landing this cycle keeps the pipeline moving without an IDLE bubble.
          state_next    = ((fifo_count > FCW'(1)) || push) ? SEND : IDLE;
        end else if (retry_reg < RETRY_MAX_C) begin
          retry_next = retry_reg + RW'(1);
          state_next = SEND;
        end else begin
          err_next   = 1'b1;
          state_next = ERR;
        end
      end
      ERR: begin
        if (err_clr) begin
          pop        = 1'b1;
          retry_next = '0;
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wen      = (state_reg == SEND);
  assign busy     = !fifo_empty || (state_reg != IDLE);
  assign err      = err_reg;
  assign tx_count = tx_count_reg;

  // Data lanes are forced to zero whenever no write is in progress.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
    assign w_data[gi] = wen ? head[gi] : '0;
  end

endmodule
